divider: RTL and testbench
==========================

Name: divider

Overview:
- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions; companion to the Multiplier in the execute stage.
- Shares the Multiplier's handshake style: the pipeline holds the select and operands stable and stalls until `ready` pulses.
- One restoring quotient bit per cycle.
- Divide-by-zero and signed overflow are resolved without iterating.

Parameters:
- XLEN, 32, operand/result width; only 32 is verified.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- divsel  input  3  operation: 000 none, 001 DIV, 010 DIVU, 011 REM, 100 REMU; 101-111 treated as none
- a  input  XLEN  dividend (rs1)
- b  input  XLEN  divisor (rs2)
- ready  output  1  result valid; one-cycle pulse
- res  output  XLEN  quotient or remainder; registered

Behaviour:
- Reset (async, any state): state=IDLE, ready=0, res=0, internal registers cleared.
- States: IDLE, CALC, DONE; `ready` = (state==DONE).
- IDLE, divsel valid, on the clock edge:
  - Latch op and sign flags. Signed ops: neg_q = a[31]^b[31], neg_r = a[31]; unsigned ops: both 0.
  - Latch |a| and |b| (raw values for unsigned ops); remainder reg = 0; count = 0.
- IDLE special cases (decided in the same edge):
  - b==0: res = quotient 32'hFFFF_FFFF or remainder a; next state DONE.
  - Signed op with a==32'h8000_0000 and b==32'hFFFF_FFFF: quotient 32'h8000_0000, remainder 0; next state DONE.
  - Otherwise next state CALC.
- CALC, each cycle (restoring step):
  - rem' = {rem[30:0], dvd[31]}; dvd shifts left.
  - If rem' >= divisor: rem = rem' - divisor and shift in 1. Else rem = rem' and shift in 0.
  - count increments. After 32 steps (count==31 edge) load res and go to DONE.
- Result correction:
  - Quotient negated (two's complement) if neg_q.
  - Remainder negated if neg_r.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE: ready=1 for exactly one cycle, then IDLE. res holds its value until the next result is loaded.
- Latency, from the edge sampling divsel to ready high: 33 cycles normal, 1 cycle for special cases.
- Pipeline contract: the pipeline advances on the cycle ready=1. If divsel is still valid in the following IDLE cycle, it is a new operation and is started.
- Abort: divsel invalid during CALC returns to IDLE at the next edge. ready stays 0 and res is unchanged.
- a, b and op are changed mid-CALC without divsel going invalid: the new values are ignored because operands are latched. Result reflects the latched values.
- Width rules:
  - Internal remainder comparison is 33 bits, so the borrow is visible.
  - |0x8000_0000| is represented as unsigned 0x8000_0000.
- No X on res or ready at any time after reset.

Decomposition:
- Package `div_pkg`:
  - divsel encodings DIVSEL_NONE/DIV/DIVU/REM/REMU.
  - state enum {IDLE, CALC, DONE}.
  - localparams DIV_BY_ZERO_Q = 32'hFFFF_FFFF and INT_MIN = 32'h8000_0000.
- One natural combinational sub-module `div_step`:
  - in: rem, dvd, divisor.
  - out: next rem, next dvd with the quotient bit shifted in.
  - Kept separate so the bench can check it exhaustively on small widths.
- Remaining logic (FSM, sign handling, counter, result mux) lives in `divider`.

Test Plan:
- DIVU a=100, b=7 -> ready 33 cycles after start, res=14. REMU same operands -> res=2.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> res=0xFFFF_FFFD (-3). REM same -> res=0xFFFF_FFFF (-1). Check both sign flips with a=7, b=-2 -> DIV -3, REM 1.
- Divide by zero, a=0x1234_5678, b=0:
  - DIV/DIVU -> res=0xFFFF_FFFF; REM/REMU -> res=0x1234_5678.
  - ready 1 cycle after start in every case.
- Overflow, DIV a=0x8000_0000, b=0xFFFF_FFFF -> res=0x8000_0000, REM -> 0, 1-cycle latency. DIVU on same operands takes 33 cycles, res=0.
- Back-to-back: hold divsel=DIVU across ready with new a/b presented on the ready cycle.
  - Second op starts the next cycle; ready pulses exactly once per op.
  - res correct for both ops.
- Reset/abort:
  - Assert rst at cycle 10 of CALC -> ready=0 and res=0 immediately (async), state IDLE.
  - Separately, drop divsel to 000 mid-CALC -> no ready pulse and res keeps its prior value.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings and constants for the RV32M iterative divider.
package div_pkg;

  localparam logic [2:0] DIVSEL_NONE = 3'b000;
  localparam logic [2:0] DIVSEL_DIV  = 3'b001;
  localparam logic [2:0] DIVSEL_DIVU = 3'b010;
  localparam logic [2:0] DIVSEL_REM  = 3'b011;
  localparam logic [2:0] DIVSEL_REMU = 3'b100;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic sel_valid(input logic [2:0] s);
    return (s == DIVSEL_DIV) || (s == DIVSEL_DIVU) || (s == DIVSEL_REM) || (s == DIVSEL_REMU);
  endfunction

  function automatic logic sel_signed(input logic [2:0] s);
    return (s == DIVSEL_DIV) || (s == DIVSEL_REM);
  endfunction

  function automatic logic sel_rem(input logic [2:0] s);
    return (s == DIVSEL_REM) || (s == DIVSEL_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift a dividend bit into the partial
// remainder, subtract the divisor if it fits, shift the quotient bit in.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_dvd,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_dvd
);

  logic [W:0]   w_sh;
  logic         w_ge;
  logic [W-1:0] w_diff;

  // Compare at W+1 bits so the carried-out MSB of the shifted remainder counts.
  // When it fits, the difference is below the divisor, so W-bit wraparound is exact.
  assign w_sh   = {i_rem, i_dvd[W-1]};
  assign w_ge   = (w_sh >= {1'b0, i_dvs});
  assign w_diff = w_sh[W-1:0] - i_dvs;
  assign o_rem  = w_ge ? w_diff : w_sh[W-1:0];
  assign o_dvd  = {i_dvd[W-2:0], w_ge};

endmodule

// File: rtl/divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle;
// divide-by-zero and signed overflow finish straight from IDLE.
module divider
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  state_t          r_state, w_state_nxt;
  logic            r_is_rem, r_neg_q, r_neg_r;
  logic [XLEN-1:0] r_rem, r_dvd, r_dvs, r_res;
  logic [CW-1:0]   r_cnt;

  logic            w_valid, w_signed, w_rem_op, w_b_zero, w_ovf, w_last;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_rem_nxt, w_dvd_nxt, w_q_fix, w_r_fix;

  assign w_valid  = sel_valid(divsel);
  assign w_signed = sel_signed(divsel);
  assign w_rem_op = sel_rem(divsel);
  assign w_b_zero = (b == '0);
  assign w_ovf    = w_signed && (a == INT_MIN) && (b == DIV_BY_ZERO_Q);
  // Magnitude of INT_MIN wraps to itself, which reads correctly as unsigned.
  assign w_a_abs  = (w_signed && a[XLEN-1]) ? -a : a;
  assign w_b_abs  = (w_signed && b[XLEN-1]) ? -b : b;
  assign w_last   = (r_cnt == CW'(XLEN-1));

  div_step #(.W(XLEN)) u_step (
    .i_rem (r_rem),
    .i_dvd (r_dvd),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_dvd (w_dvd_nxt)
  );

  assign w_q_fix = r_neg_q ? -w_dvd_nxt : w_dvd_nxt;
  assign w_r_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    case (r_state)
      IDLE: if (w_valid) w_state_nxt = (w_b_zero || w_ovf) ? DONE : CALC;
      // Dropping divsel mid-iteration abandons the operation.
      CALC: if (!w_valid) w_state_nxt = IDLE;
            else if (w_last) w_state_nxt = DONE;
      DONE: begin
        ready       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_res    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_valid) begin
          r_is_rem <= w_rem_op;
          r_neg_q  <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
          r_neg_r  <= w_signed && a[XLEN-1];
          r_dvd    <= w_a_abs;
          r_dvs    <= w_b_abs;
          r_rem    <= '0;
          r_cnt    <= '0;
          if (w_b_zero)  r_res <= w_rem_op ? a : DIV_BY_ZERO_Q;
          else if (w_ovf) r_res <= w_rem_op ? '0 : INT_MIN;
        end
        CALC: if (w_valid) begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_dvd_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_res <= r_is_rem ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

  assign res = r_res;

endmodule

// File: tb/tb_divider.sv
// Scoreboarded directed test of the iterative divider: the driver queues
// expected results and latencies, the monitor checks every ready pulse.
module tb_divider;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  divsel = DIVSEL_NONE;
  logic [31:0] a = '0, b = '0;
  logic        ready;
  logic [31:0] res;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          start;
    string       nm;
  } exp_t;
  exp_t sb[$];

  divider #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .divsel (divsel),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .res    (res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_res"}, res, e.res);
        chk({e.nm, "_lat"}, 32'(cyc - e.start + 1), 32'(e.lat));
      end
    end
  end

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) return;
    end
    chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [2:0] sel, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] er, input int lat);
    exp_t e;
    @(negedge clk);
    divsel = sel; a = va; b = vb;
    e.res = er; e.lat = lat; e.start = cyc + 1; e.nm = nm;
    sb.push_back(e);
    wait_ready(nm);
    divsel = DIVSEL_NONE;
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_res", res, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7",   DIVSEL_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7",   DIVSEL_REMU, 32'd100, 32'd7, 32'd2,  33);
    run_op("div_m7_2",     DIVSEL_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",     DIVSEL_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2",     DIVSEL_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",     DIVSEL_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div_m100_m7",  DIVSEL_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
    run_op("rem_m100_m7",  DIVSEL_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33);
    run_op("divu_max_1",   DIVSEL_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("remu_max_10",  DIVSEL_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 33);
    run_op("div_by0",      DIVSEL_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("divu_by0",     DIVSEL_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0",      DIVSEL_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run_op("remu_by0",     DIVSEL_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run_op("div_ovf",      DIVSEL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",      DIVSEL_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_ovfops",  DIVSEL_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("remu_ovfops",  DIVSEL_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

    // Back-to-back: divsel held across ready, new operands on the ready cycle.
    @(negedge clk);
    divsel = DIVSEL_DIVU; a = 32'd100; b = 32'd7;
    e.res = 32'd14; e.lat = 33; e.start = cyc + 1; e.nm = "b2b_first";
    sb.push_back(e);
    wait_ready("b2b_first");
    a = 32'd1000; b = 32'd3;
    e.res = 32'd333; e.lat = 33; e.start = cyc + 2; e.nm = "b2b_second";
    sb.push_back(e);
    @(negedge clk);
    wait_ready("b2b_second");
    divsel = DIVSEL_NONE;

    // Operands and op changed mid-iteration are ignored.
    @(negedge clk);
    divsel = DIVSEL_DIVU; a = 32'd1000; b = 32'd3;
    e.res = 32'd333; e.lat = 33; e.start = cyc + 1; e.nm = "latched_ops";
    sb.push_back(e);
    repeat (5) @(negedge clk);
    divsel = DIVSEL_REMU; a = 32'd5; b = 32'd1;
    wait_ready("latched_ops");
    divsel = DIVSEL_NONE;

    // Async reset mid-iteration.
    @(negedge clk);
    divsel = DIVSEL_DIVU; a = 32'd1000; b = 32'd3;
    repeat (10) @(negedge clk);
    divsel = DIVSEL_NONE;
    rst = 1'b1;
    #1;
    chk("midcalc_rst_ready", {31'd0, ready}, 32'd0);
    chk("midcalc_rst_res", res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_op("after_rst",    DIVSEL_REMU, 32'd100, 32'd7, 32'd2, 33);

    // Abort by dropping divsel: no pulse, res keeps the previous result.
    @(negedge clk);
    divsel = DIVSEL_DIVU; a = 32'd1000; b = 32'd3;
    repeat (10) @(negedge clk);
    divsel = DIVSEL_NONE;
    repeat (40) @(negedge clk);
    chk("abort_res_hold", res, 32'd2);
    run_op("after_abort",  DIVSEL_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
